// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1/8N2 UART transmitter among P_REQ_NUM
// byte-stream requesters; baud timing is derived from the system clock.
module uart_tx_arbiter #(
  parameter int P_SYS_CLK        = 100_000_000,
  parameter int P_UART_BAUD_RATE = 115200,
  parameter int P_REQ_NUM        = 4,
  parameter int P_STOP_BITS      = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [P_REQ_NUM-1:0]         i_req_valid,
  input  logic [8*P_REQ_NUM-1:0]       i_req_data,
  output logic [P_REQ_NUM-1:0]         o_req_ready,
  output logic [$clog2(P_REQ_NUM)-1:0] o_grant_id,
  output logic                         o_busy,
  output logic                         o_uart_tx
);

  localparam int          DIV       = P_SYS_CLK / P_UART_BAUD_RATE;
  localparam int          CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int          IW        = $clog2(P_REQ_NUM);
  localparam int unsigned NREQ      = P_REQ_NUM;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(P_STOP_BITS - 1);
  localparam logic [IW-1:0] LAST_ID = IW'(P_REQ_NUM - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          tx_q, tx_d;

  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          found;
  logic          hs;
  logic          tick;
  int unsigned   idx;

  // First valid requester at or above rr_ptr, wrapping modulo P_REQ_NUM.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IW'(idx);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign hs = (state_q == IDLE) && found && !reset;

  always_comb begin
    o_req_ready = '0;
    if (hs) o_req_ready[sel] = 1'b1;
  end

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hs) begin
          data_d   = i_req_data[{sel, 3'b000} +: 8];
          grant_d  = sel;
          rr_ptr_d = (sel == LAST_ID) ? '0 : sel + 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        // bit_idx is reused to count stop bits.
        if (tick) begin
          if (bit_idx_q == STOP_LAST) begin
            state_d   = IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so the pin is glitch-free.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      tx_q      <= tx_d;
    end
  end

  assign o_busy     = (state_q != IDLE);
  assign o_uart_tx  = tx_q;
  assign o_grant_id = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line between `P_REQ_NUM` byte-stream requesters. Each accepted byte is serialised as an 8N1/8N2 frame using an internal baud-tick divider from the system clock. Requesters are served by round-robin arbitration with a valid/ready handshake. The block sits between on-chip byte producers (debug, status, command-response) and the UART TX pin.

## Interface
- `P_SYS_CLK`, 100_000_000: system clock frequency, Hz.
- `P_UART_BAUD_RATE`, 115200: line rate, bps.
- `P_REQ_NUM`, 4: number of requesters, 2..8.
- `P_STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clock`  in  1: system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `i_req_valid`  in  P_REQ_NUM: requester k has a byte pending.
- `i_req_data`  in  8*P_REQ_NUM: byte of requester k at bits [8k+7:8k].
- `o_req_ready`  out  P_REQ_NUM: one-hot accept strobe; the transfer occurs when `valid[k] & ready[k]`.
- `o_grant_id`  out  clog2(P_REQ_NUM): index of the requester whose frame is in flight or was last sent.
- `o_busy`  out  1: frame in progress.
- `o_uart_tx`  out  1: serial line, idle high.

## Operation
- DIV = P_SYS_CLK / P_UART_BAUD_RATE, integer floor; DIV must be at least 2. The bit counter is clog2(DIV) bits wide and counts 0..DIV-1.
- The bit tick fires when the counter equals DIV-1, then the counter wraps to 0. The counter is held at 0 in IDLE, so every bit lasts exactly DIV cycles.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - `o_uart_tx`=1 and `o_busy`=0.
  - If any valid bit is set, select the first set index searching upward from pointer `rr_ptr`, modulo P_REQ_NUM.
  - Assert `o_req_ready` combinationally for that index only, in that cycle.
  - On the handshake: latch the data byte, set `o_grant_id` to the selected index, set `rr_ptr` to (index+1) mod P_REQ_NUM, and go to START.
- START: `o_uart_tx`=0 for DIV cycles, then go to DATA.
- DATA:
  - Send 8 bits LSB first, each for DIV cycles.
  - A 3-bit bit index counts 0..7.
  - After bit 7's tick, go to STOP.
- STOP: `o_uart_tx`=1 for P_STOP_BITS×DIV cycles, then go to IDLE.
- `o_req_ready` is 0 in every state except IDLE, and 0 while `reset`=1.
- A requester must hold valid and data stable until ready; data is sampled only at the handshake. Withdrawing valid before ready is legal; that requester is simply skipped.
- Simultaneous requests: exactly one is granted per IDLE cycle, by rotating priority. No requester waits more than P_REQ_NUM-1 frames.
- Only one `o_req_ready` bit is ever high.

## Timing
- Reset (one `clock` edge with `reset`=1) sets:
  - state to IDLE;
  - `o_uart_tx`=1, `o_busy`=0, `o_grant_id`=0;
  - `rr_ptr`=0;
  - bit counter and bit index to 0.
- Reset mid-frame abandons the frame immediately. The line is high at the first edge after reset and the lost byte is not re-requested.
- Handshake in cycle T:
  - `o_uart_tx`=0 and `o_busy`=1 from T+1.
  - Start bit spans T+1..T+DIV.
  - Data bit i spans T+1+(i+1)·DIV .. T+(i+2)·DIV.
  - The last stop-bit cycle is T+(9+P_STOP_BITS)·DIV.
- The cycle after the last stop-bit cycle is IDLE with `o_busy`=0. The earliest next handshake is in that cycle.
- The back-to-back frame period is therefore (9+P_STOP_BITS)·DIV+1 cycles.
- `o_busy` is high for exactly (9+P_STOP_BITS)·DIV cycles per frame.
- `o_grant_id` updates at T+1 and holds until the next handshake.

## Test plan
Settings unless stated: P_SYS_CLK=1_000_000, P_UART_BAUD_RATE=100_000 (DIV=10), P_REQ_NUM=4, P_STOP_BITS=1.

- **Single frame.** Requester 0 sends 0xA5 from idle.
  - `o_req_ready[0]` high for 1 cycle; `o_grant_id`=0.
  - Line is 0 for 10 cycles, then 1,0,1,0,0,1,0,1 for 10 cycles each, then 1 for 10 cycles.
  - `o_busy` high for exactly 100 cycles.
- **Round-robin from reset.** All four valid with data 0x10..0x13.
  - Grants in order 0,1,2,3; handshakes 101 cycles apart.
  - Decoded bytes are 0x10, 0x11, 0x12, 0x13.
- **Fairness.** Requester 0 holds valid continuously; requester 2 raises valid during frame 1.
  - Grant order is 0,2,0.
  - Requester 0 is never granted twice while 2 is pending.
- **Reset mid-frame.** Assert `reset` for 1 cycle during data bit 3.
  - Line is 1 and `o_busy`=0 the next cycle.
  - A subsequent request from requester 3 produces a complete clean frame, with `o_grant_id`=3.
- **Two stop bits.** P_STOP_BITS=2, byte 0xFF.
  - Frame is 110 cycles: 10 low, then 100 high.
  - Back-to-back period is 111 cycles.
- **Idle and withdraw.** No valid input: line stays 1 and `o_req_ready`=0 for 1000 cycles. Requester 1 raises valid, then drops it while busy with another requester: it is never acked and no frame is emitted for it.
